// File: rtl/mem_arbiter.sv
// Arbiter sharing one multi-cycle single-ported memory between the fetch port and the data port.
// Issues one access at a time, returns data to the owner, generates stalls and a sticky timeout flag.
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_flush,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] i_rdata,
  output logic        i_valid,
  output logic        i_stall,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            squash_q, squash_d;
  logic            last_data_q, last_data_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_wr_q, mem_wr_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;

  logic idle, busy, i_elig, grant_d, grant_i, timeout, finish;

  // A redirect blocks only the fetch grant; data may still win in the same cycle.
  assign idle    = (state_q == IDLE);
  assign busy    = ~idle;
  assign i_elig  = i_req & ~i_flush;
  assign grant_d = idle & ~halt & d_req & ~(i_elig & last_data_q);
  assign grant_i = idle & ~halt & i_elig & ~grant_d;
  assign timeout = busy & ~mem_done & (cnt_q == CW'(TIMEOUT - 1));
  assign finish  = busy & (mem_done | timeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = DBUSY;
        else if (grant_i) state_d = IBUSY;
      end
      IBUSY, DBUSY: if (finish) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    i_valid = (state_q == IBUSY) & mem_done & ~squash_q & ~i_flush;
    d_valid = (state_q == DBUSY) & mem_done;
    i_rdata = i_valid ? mem_rdata : 16'h0000;
    d_rdata = d_valid ? mem_rdata : 16'h0000;
    // Gated by reset so every output reads zero while reset is held.
    i_stall = rst & i_req & ~i_valid;
    d_stall = rst & d_req & ~d_valid;
  end

  always_comb begin
    cnt_d       = (busy & ~finish) ? cnt_q + CW'(1) : '0;
    squash_d    = squash_q;
    if (finish)                             squash_d = 1'b0;
    else if ((state_q == IBUSY) & i_flush)  squash_d = 1'b1;
    err_d       = err_q | timeout;
    mem_en_d    = grant_d | grant_i;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    last_data_d = last_data_q;
    if (grant_d) begin
      mem_addr_d  = d_addr;
      mem_wr_d    = d_wr;
      mem_wdata_d = d_wdata;
      last_data_d = 1'b1;
    end else if (grant_i) begin
      mem_addr_d  = i_addr;
      mem_wr_d    = 1'b0;
      mem_wdata_d = 16'h0000;
      last_data_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      squash_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      last_data_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      squash_q    <= squash_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      last_data_q <= last_data_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable memory model plus scoreboards of expected
// issues and returned words, popped as the arbiter produces mem_en / valid pulses.
module tb_mem_arbiter;

  logic        clk, rst, halt;
  logic        i_req, i_flush, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        i_valid, i_stall, d_valid, d_stall, mem_en, mem_wr, mem_done, err;

  mem_arbiter #(.TIMEOUT(64), .CW(7)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_iv  = 0;
  int n_dv  = 0;
  int lat   = 2;
  int rem   = -1;
  logic hold = 1'b0;
  logic [15:0] m_a, m_wd;
  logic        m_wr;

  logic [32:0] exp_iss[$];
  logic [15:0] exp_i[$];
  logic [15:0] exp_d[$];
  logic [32:0] mon_e;
  logic [15:0] mon_w;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic at_pos();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_iv(input int target);
    for (int k = 0; k < 200 && n_iv < target; k++) at_pos();
    chk_eq("wait_i_valid", 32'(n_iv >= target), 1);
  endtask

  task automatic wait_dv(input int target);
    for (int k = 0; k < 200 && n_dv < target; k++) at_pos();
    chk_eq("wait_d_valid", 32'(n_dv >= target), 1);
  endtask

  // Memory: done arrives 'lat' cycles after the mem_en cycle; reads return ~addr, writes echo wdata.
  initial begin
    mem_done  = 1'b0;
    mem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_rdata = 16'hDEAD;
      if (rem > 0) begin
        rem--;
        if (rem == 0 && !hold) begin
          mem_done  = 1'b1;
          mem_rdata = m_wr ? m_wd : ~m_a;
        end
      end
      if (mem_en) begin
        rem  = lat;
        m_a  = mem_addr;
        m_wr = mem_wr;
        m_wd = mem_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      if (exp_iss.size() == 0) chk_eq("iss_unexpected", 32'(mem_en), 0);
      else begin
        mon_e = exp_iss.pop_front();
        $display("[%0t] issue wr=%0b addr=%h wdata=%h", $time, mem_wr, mem_addr, mem_wdata);
        chk_eq("iss_wr_addr", {15'd0, mem_wr, mem_addr}, {15'd0, mon_e[32:16]});
        if (mon_e[32]) chk_eq("iss_wdata", {16'd0, mem_wdata}, {16'd0, mon_e[15:0]});
      end
    end
    if (i_valid) begin
      n_iv++;
      $display("[%0t] fetch done rdata=%h", $time, i_rdata);
      if (exp_i.size() == 0) chk_eq("i_unexpected", 32'(i_valid), 0);
      else begin
        mon_w = exp_i.pop_front();
        chk_eq("i_rdata", {16'd0, i_rdata}, {16'd0, mon_w});
      end
    end else chk_eq("i_rdata_zero", {16'd0, i_rdata}, 0);
    if (d_valid) begin
      n_dv++;
      $display("[%0t] data done rdata=%h", $time, d_rdata);
      if (exp_d.size() == 0) chk_eq("d_unexpected", 32'(d_valid), 0);
      else begin
        mon_w = exp_d.pop_front();
        chk_eq("d_rdata", {16'd0, d_rdata}, {16'd0, mon_w});
      end
    end else chk_eq("d_rdata_zero", {16'd0, d_rdata}, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int nd, ni;

  initial begin
    // Reset with both requests already raised (arbitration from reset).
    rst = 1'b0; halt = 1'b0; i_flush = 1'b0;
    i_req = 1'b1; i_addr = 16'h0020;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    repeat (3) at_neg();
    chk_eq("rst_mem_en", 32'(mem_en), 0);
    chk_eq("rst_mem_addr", {16'd0, mem_addr}, 0);
    chk_eq("rst_err", 32'(err), 0);
    chk_eq("rst_i_stall", 32'(i_stall), 0);
    chk_eq("rst_d_stall", 32'(d_stall), 0);
    chk_eq("rst_valids", {30'd0, i_valid, d_valid}, 0);

    // Contention: D first, then strict alternation D,I,D,I.
    exp_iss.push_back({1'b1, 16'h0100, 16'hBEEF});
    exp_iss.push_back({1'b0, 16'h0020, 16'h0000});
    exp_iss.push_back({1'b1, 16'h0100, 16'hBEEF});
    exp_iss.push_back({1'b0, 16'h0020, 16'h0000});
    exp_d.push_back(16'hBEEF); exp_i.push_back(~16'h0020);
    exp_d.push_back(16'hBEEF); exp_i.push_back(~16'h0020);
    at_pos(); rst = 1'b1;
    wait_iv(2);
    i_req = 1'b0; d_req = 1'b0;
    chk_eq("alt_d_count", n_dv, 2);

    // Single fetch, latency check.
    at_pos();
    at_pos(); i_req = 1'b1; i_addr = 16'h0010;
    exp_iss.push_back({1'b0, 16'h0010, 16'h0000}); exp_i.push_back(~16'h0010);
    at_neg(); chk_eq("f_t0_stall", 32'(i_stall), 1); chk_eq("f_t0_en", 32'(mem_en), 0);
    at_pos(); at_neg();
    chk_eq("f_t1_en", 32'(mem_en), 1);
    chk_eq("f_t1_addr", {16'd0, mem_addr}, 32'h0010);
    chk_eq("f_t1_wr", 32'(mem_wr), 0);
    chk_eq("f_t1_stall", 32'(i_stall), 1);
    at_pos(); at_neg();
    chk_eq("f_t2_en", 32'(mem_en), 0);
    chk_eq("f_t2_stall", 32'(i_stall), 1);
    at_pos(); at_neg();
    chk_eq("f_t3_valid", 32'(i_valid), 1);
    chk_eq("f_t3_stall", 32'(i_stall), 0);
    at_pos(); i_req = 1'b0;

    // Redirect while the fetch is in flight.
    at_pos(); i_req = 1'b1; i_addr = 16'h0030;
    exp_iss.push_back({1'b0, 16'h0030, 16'h0000});
    ni = n_iv;
    at_pos();
    at_pos(); i_flush = 1'b1; i_addr = 16'h0040;
    exp_iss.push_back({1'b0, 16'h0040, 16'h0000}); exp_i.push_back(~16'h0040);
    at_pos(); i_flush = 1'b0;
    at_neg();
    chk_eq("flush_no_valid", 32'(i_valid), 0);
    chk_eq("flush_stall", 32'(i_stall), 1);
    at_pos();
    wait_iv(ni + 1);
    i_req = 1'b0;
    chk_eq("flush_iv_count", n_iv, ni + 1);

    // Timeout: withheld done, then regrant succeeds with err still set.
    at_pos(); hold = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    exp_iss.push_back({1'b0, 16'h0200, 16'h0000});
    exp_iss.push_back({1'b0, 16'h0200, 16'h0000}); exp_d.push_back(~16'h0200);
    nd = n_dv;
    repeat (64) at_pos();
    at_neg();
    chk_eq("to_err_before", 32'(err), 0);
    at_pos(); hold = 1'b0;
    at_neg();
    chk_eq("to_err_set", 32'(err), 1);
    chk_eq("to_no_dv", n_dv, nd);
    chk_eq("to_d_stall", 32'(d_stall), 1);
    chk_eq("to_idle_en", 32'(mem_en), 0);
    at_pos();
    wait_dv(nd + 1);
    d_req = 1'b0;
    chk_eq("to_err_sticky", 32'(err), 1);

    // Halt blocks new grants but not an access in flight.
    at_pos(); halt = 1'b1; i_req = 1'b1; i_addr = 16'h0050;
    repeat (5) begin
      at_neg(); chk_eq("halt_idle_en", 32'(mem_en), 0);
      at_pos();
    end
    halt = 1'b0; i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0060;
    exp_iss.push_back({1'b0, 16'h0060, 16'h0000}); exp_d.push_back(~16'h0060);
    nd = n_dv; ni = n_iv;
    at_pos(); halt = 1'b1; i_req = 1'b1;
    wait_dv(nd + 1);
    d_req = 1'b0;
    repeat (6) begin
      at_neg(); chk_eq("halt_busy_en", 32'(mem_en), 0);
      at_pos();
    end
    chk_eq("halt_dv_count", n_dv, nd + 1);
    halt = 1'b0;
    exp_iss.push_back({1'b0, 16'h0050, 16'h0000}); exp_i.push_back(~16'h0050);
    wait_iv(ni + 1);
    i_req = 1'b0;

    // Asynchronous reset in the middle of a data write.
    at_pos(); lat = 4; d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0070; d_wdata = 16'h1234;
    exp_iss.push_back({1'b1, 16'h0070, 16'h1234});
    nd = n_dv;
    at_pos();
    at_pos(); rst = 1'b0;
    #1;
    chk_eq("arst_addr", {16'd0, mem_addr}, 0);
    chk_eq("arst_wdata", {16'd0, mem_wdata}, 0);
    chk_eq("arst_wr", 32'(mem_wr), 0);
    chk_eq("arst_d_stall", 32'(d_stall), 0);
    chk_eq("arst_err", 32'(err), 0);
    at_pos(); d_req = 1'b0; rst = 1'b1;
    repeat (4) at_pos();
    chk_eq("arst_no_dv", n_dv, nd);
    lat = 2; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0080;
    exp_iss.push_back({1'b0, 16'h0080, 16'h0000}); exp_d.push_back(~16'h0080);
    wait_dv(nd + 1);
    d_req = 1'b0;
    at_pos();

    chk_eq("left_iss", exp_iss.size(), 0);
    chk_eq("left_i", exp_i.size(), 0);
    chk_eq("left_d", exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, multi-cycle unified memory between the fetch stage's instruction port (read-only) and the memory stage's data port (read/write).
- Grants one requester at a time, sequences the issue/done handshake with memory, and returns data to the granted requester.
- Generates the stall signal each stage uses to hold its pipeline register.
- Squashes in-flight fetches on branch/jump redirect.
- Flags a memory timeout.

Parameters:
TIMEOUT, 64, busy-state cycles without mem_done before err is raised
CW, 7, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
halt  in  1  block new grants; an in-flight access still completes
i_req  in  1  fetch read request, level, held until i_valid
i_addr  in  16  fetch address (current PC)
i_flush  in  1  redirect (Branch_EXMEM or Jump); squash the pending/in-flight fetch
d_req  in  1  data request, level, held until d_valid
d_wr  in  1  1=write, 0=read; sampled with d_req at grant
d_addr  in  16  data address
d_wdata  in  16  write data
i_rdata  out  16  instruction word, valid with i_valid
i_valid  out  1  1-cycle pulse: fetch complete
i_stall  out  1  i_req & ~i_valid
d_rdata  out  16  read data, valid with d_valid
d_valid  out  1  1-cycle pulse: data access complete (read or write)
d_stall  out  1  d_req & ~d_valid
mem_en  out  1  1-cycle issue pulse to memory
mem_wr  out  1  write qualifier for mem_en
mem_addr  out  16  registered address, held through the access
mem_wdata  out  16  registered write data, held through the access
mem_rdata  in  16  memory read data, valid with mem_done
mem_done  in  1  memory access complete; never earlier than the cycle after mem_en
err  out  1  sticky timeout error

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; mem_addr/mem_wdata=0.
  - squash=0; last_grant=INSTR; counter=0.
  - Takes effect mid-access: the in-flight access is abandoned and no valid pulse is produced.
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE:
  - If halt=1, or i_flush=1 with only i_req pending: no grant.
  - Else grant per the arbitration rule below.
  - On grant at edge T: register addr/wr/wdata into mem_*; mem_en=1 during cycle T+1 only; state moves to IBUSY or DBUSY.
- Arbitration:
  - d_req only → D; i_req only → I.
  - Both pending → D, unless last_grant=DATA, then I. This alternates under sustained contention.
  - last_grant updates on every grant.
- IBUSY/DBUSY:
  - Counter increments each cycle; inputs other than i_flush are ignored.
  - On mem_done: capture nothing; pass mem_rdata combinationally to i_rdata or d_rdata.
  - In the same cycle pulse the matching valid (i_valid is suppressed if squash=1), clear squash and counter, and return to IDLE.
  - Earliest next grant is the following cycle, so accesses are spaced by at least one IDLE cycle.
- i_flush:
  - In IBUSY it sets squash; the result is discarded and no i_valid is produced.
  - i_stall stays asserted until the re-fetch to the new PC completes.
  - In DBUSY, or in IDLE with no grant, it has no effect beyond blocking the I grant that cycle.
  - i_flush coincident with mem_done in IBUSY squashes that completion.
- Timeout:
  - Counter reaches TIMEOUT with no mem_done → err=1 (sticky until reset) and state returns to IDLE.
  - No valid pulse is produced; the requester stays stalled and may be regranted.
  - A mem_done while in IDLE is ignored.
- Outputs i_rdata/d_rdata are 0 whenever the corresponding valid is 0.
- mem_wr is 0 for all instruction grants.
- halt does not abort busy states.

Test Plan:
1. Memory model with 3-cycle done latency; i_req=1, i_addr=0x0010 at T0 → mem_en at T1 with mem_addr=0x0010, mem_wr=0. mem_done at T3 → i_valid=1 and i_rdata=mem_rdata at T3; i_stall=1 during T0–T2.
2. i_req and d_req (d_wr=1, d_addr=0x0100, d_wdata=0xBEEF) both asserted from reset → D is granted first with mem_wr=1 and mem_wdata=0xBEEF, d_valid pulses; then I is granted. With both held continuously, grants alternate D,I,D,I.
3. Fetch in IBUSY; i_flush pulses one cycle after mem_en → no i_valid at mem_done. The next I grant uses the new i_addr=0x0040, and i_valid follows for 0x0040 only.
4. mem_done withheld for 64 busy cycles → err=1 at cycle 64, state IDLE, no valid pulse; a later successful access leaves err=1.
5. halt=1 with i_req pending in IDLE → mem_en stays 0. halt asserted during DBUSY → access completes with a d_valid pulse, and no further grant occurs until halt=0.
6. rst driven low asynchronously mid-DBUSY → all outputs 0 immediately; a later mem_done yields no d_valid. After release, a normal access completes.
